mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified instruction/data memory port between the fetch (I) requester and the load/store (D) requester.
//  Grants one transaction at a time: an I burst refill (BEATS words), a D read (one N-bit word) or a D write (one-cycle memwrite).
//  Sits between the fetch/MEM stages and the memory. Guarantees instrreq/datareq/memwrite are never active together.
//  Drives the stall (d_stall) that holds the pipeline while a D access is pending.
// PARAMETERS
//  N        64  data/address width of the D side and memory data port
//  BEATS    8   instruction words per I burst
//  TIMEOUT  15  max cycles without memory progress before a grant is forcibly ended (TIMEOUT >= 2)
// PORTS
//  clk          in   1   clock, all state on posedge
//  reset        in   1   synchronous, active-low reset (0 = reset)
//  i_req        in   1   fetch request; level, held until i_done
//  i_adr        in   32  burst start byte address
//  i_data       out  32  returned instruction word
//  i_valid      out  1   i_data valid this cycle (one per beat)
//  i_done       out  1   1-cycle pulse: burst finished or timed out
//  d_req        in   1   load/store request; level, held until d_done
//  d_adr        in   N   byte address
//  d_memwrite   in   2   0 read, 1 word, 2 byte, 3 dword write
//  d_wdata      in   N   write data
//  d_rdata      out  N   read data, valid from the d_done cycle until the next D read completes
//  d_done       out  1   1-cycle completion pulse
//  d_stall      out  1   = d_req & ~d_done (combinational)
//  err          out  1   1-cycle pulse on timeout (coincides with the owner's done)
//  m_instrreq   out  1   memory I-burst request
//  m_instradr   out  32  latched i_adr
//  m_instr      in   32  memory instruction word
//  m_val        in   1   memory beat valid
//  m_datareq    out  1   memory D read request
//  m_dataadr    out  N   latched d_adr
//  m_memwrite   out  2   memory write strobe code
//  m_writedata  out  N   latched d_wdata
//  m_readdata   in   N   memory read data
//  m_dack       in   1   memory D read data valid
// BEHAVIOUR
//  States: IDLE, IGNT, DRD, DWR.
//  Reset: state IDLE, all outputs 0, beat/watchdog counters 0, last_owner = D (I wins the first tie).
//  Reset mid-transfer aborts at once; no done pulse. The requester reissues.
//  IDLE decision, registered:
//   - both pending: the requester that was NOT last_owner wins (round-robin).
//   - a single pending request wins.
//   - D winner goes to DWR if d_memwrite != 0, else DRD.
//   - Address, write code and write data are latched at grant. Input changes during a grant are ignored.
//  IGNT:
//   - m_instrreq=1 and m_instradr=latched.
//   - Each m_val cycle: i_data <= m_instr, i_valid=1 next cycle, beat++.
//   - Beat BEATS-1 accepted: i_done pulses with the last i_valid, m_instrreq drops, last_owner=I, go to IDLE.
//  DRD:
//   - m_datareq=1.
//   - First m_dack: d_rdata <= m_readdata, d_done=1 next cycle, last_owner=D, go to IDLE.
//  DWR:
//   - m_memwrite = latched code for exactly one cycle.
//   - d_done pulses the following cycle, last_owner=D, go to IDLE.
//   - Write latency 2 cycles from grant.
//  Latency: grant 1 cycle after req seen in IDLE. Minimum 1 idle cycle between grants.
//  Watchdog: counts cycles in IGNT/DRD since the last beat/ack, cleared on progress.
//   - At TIMEOUT: owner's done + err pulse together, requests drop, go to IDLE.
//   - Partial I beats already delivered stand.
//  Request deasserted before grant: no effect. Deasserted mid-grant: transfer still completes.
//  m_val/m_dack arriving outside their state are ignored.
//  Beat counter is log2(BEATS)+1 bits and never wraps within a burst.
// CONFIGURATION
//  ARB_PERF_EN defined adds ports:
//   - perf_igrant, perf_dgrant, perf_conflict (out, 32 each).
//   - Counting: I grants, D grants, IDLE cycles with both requests pending.
//   - Saturating at 2^32-1, cleared by reset.
//  ARB_PERF_EN undefined: ports absent, no counter logic.
// TESTING
//  I only, i_adr=0x40, memory gives 8 beats 0xA0..0xA7 -> 8 i_valid with same data, i_done on 8th, m_instrreq low after.
//  D read d_adr=0x18, m_dack after 3 cycles with 0x1234 -> d_rdata=0x1234, one d_done, d_stall high until then.
//  D write d_memwrite=2, d_adr=0x7 -> m_memwrite=2 for exactly 1 cycle with latched adr/data, d_done next cycle.
//  i_req and d_req rise same cycle after reset -> I granted first, D granted after i_done; repeat -> D first.
//  DRD with m_dack never asserted -> d_done and err pulse 15 cycles after grant, state IDLE.
//  Reset low during beat 4 of IGNT -> next cycle all outputs 0, no i_done, fresh i_req regranted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory port between fetch bursts and load/store accesses.
// Define ARB_PERF_EN to add saturating grant/conflict performance counters.
module mem_port_arbiter #(
  parameter int N       = 64,
  parameter int BEATS   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req,
  input  logic [31:0]  i_adr,
  output logic [31:0]  i_data,
  output logic         i_valid,
  output logic         i_done,
  input  logic         d_req,
  input  logic [N-1:0] d_adr,
  input  logic [1:0]   d_memwrite,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_done,
  output logic         d_stall,
  output logic         err,
  output logic         m_instrreq,
  output logic [31:0]  m_instradr,
  input  logic [31:0]  m_instr,
  input  logic         m_val,
  output logic         m_datareq,
  output logic [N-1:0] m_dataadr,
  output logic [1:0]   m_memwrite,
  output logic [N-1:0] m_writedata,
  input  logic [N-1:0] m_readdata,
  input  logic         m_dack
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]  perf_igrant,
  output logic [31:0]  perf_dgrant,
  output logic [31:0]  perf_conflict
`endif
);

  localparam int BW = $clog2(BEATS) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [WW-1:0] WDOG_MAX  = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, IGNT, DRD, DWR} state_t;

  state_t        state;
  logic [BW-1:0] beat;
  logic [WW-1:0] wdog;
  logic          last_owner_i;
  logic          i_pend;
  logic          d_pend;
  logic          grant_i;
  logic          grant_d;

  // A requester still sees its own done pulse in the first IDLE cycle, so mask it out
  // to keep a just-finished requester from being regranted before it can drop req.
  assign i_pend  = i_req & ~i_done;
  assign d_pend  = d_req & ~d_done;
  assign d_stall = d_req & ~d_done;
  assign grant_i = (state == IDLE) && i_pend && (!d_pend || !last_owner_i);
  assign grant_d = (state == IDLE) && d_pend && !grant_i;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      beat         <= '0;
      wdog         <= '0;
      last_owner_i <= 1'b0;
      i_data       <= '0;
      i_valid      <= 1'b0;
      i_done       <= 1'b0;
      d_rdata      <= '0;
      d_done       <= 1'b0;
      err          <= 1'b0;
      m_instrreq   <= 1'b0;
      m_instradr   <= '0;
      m_datareq    <= 1'b0;
      m_dataadr    <= '0;
      m_memwrite   <= '0;
      m_writedata  <= '0;
    end else begin
      i_valid <= 1'b0;
      i_done  <= 1'b0;
      d_done  <= 1'b0;
      err     <= 1'b0;
      case (state)
        IDLE: begin
          beat <= '0;
          wdog <= '0;
          if (grant_i) begin
            state      <= IGNT;
            m_instrreq <= 1'b1;
            m_instradr <= i_adr;
          end else if (grant_d) begin
            m_dataadr   <= d_adr;
            m_writedata <= d_wdata;
            if (d_memwrite != 2'd0) begin
              state      <= DWR;
              m_memwrite <= d_memwrite;
            end else begin
              state     <= DRD;
              m_datareq <= 1'b1;
            end
          end
        end
        IGNT: begin
          if (m_val) begin
            i_data  <= m_instr;
            i_valid <= 1'b1;
            wdog    <= '0;
            beat    <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              i_done       <= 1'b1;
              m_instrreq   <= 1'b0;
              last_owner_i <= 1'b1;
              state        <= IDLE;
            end
          end else if (wdog == WDOG_MAX) begin
            i_done       <= 1'b1;
            err          <= 1'b1;
            m_instrreq   <= 1'b0;
            last_owner_i <= 1'b1;
            state        <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DRD: begin
          if (m_dack) begin
            d_rdata      <= m_readdata;
            d_done       <= 1'b1;
            m_datareq    <= 1'b0;
            last_owner_i <= 1'b0;
            state        <= IDLE;
          end else if (wdog == WDOG_MAX) begin
            d_done       <= 1'b1;
            err          <= 1'b1;
            m_datareq    <= 1'b0;
            last_owner_i <= 1'b0;
            state        <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DWR: begin
          m_memwrite   <= 2'd0;
          d_done       <= 1'b1;
          last_owner_i <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_igrant   <= '0;
      perf_dgrant   <= '0;
      perf_conflict <= '0;
    end else begin
      if (grant_i && perf_igrant != 32'hFFFF_FFFF)
        perf_igrant <= perf_igrant + 32'd1;
      if (grant_d && perf_dgrant != 32'hFFFF_FFFF)
        perf_dgrant <= perf_dgrant + 32'd1;
      if (state == IDLE && i_pend && d_pend && perf_conflict != 32'hFFFF_FFFF)
        perf_conflict <= perf_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by randomized transactions
// checked against a round-robin ownership model and bench-chosen memory data.
module tb_mem_port_arbiter;

  localparam int N       = 64;
  localparam int BEATS   = 8;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_req;
  logic [31:0]  i_adr;
  logic [31:0]  i_data;
  logic         i_valid;
  logic         i_done;
  logic         d_req;
  logic [N-1:0] d_adr;
  logic [1:0]   d_memwrite;
  logic [N-1:0] d_wdata;
  logic [N-1:0] d_rdata;
  logic         d_done;
  logic         d_stall;
  logic         err;
  logic         m_instrreq;
  logic [31:0]  m_instradr;
  logic [31:0]  m_instr;
  logic         m_val;
  logic         m_datareq;
  logic [N-1:0] m_dataadr;
  logic [1:0]   m_memwrite;
  logic [N-1:0] m_writedata;
  logic [N-1:0] m_readdata;
  logic         m_dack;

  int checks   = 0;
  int failures = 0;

  // Reference state: who owned the port last, and what a D read last returned.
  logic         model_last_i;
  logic [N-1:0] model_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N(N), .BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_adr(i_adr), .i_data(i_data), .i_valid(i_valid), .i_done(i_done),
    .d_req(d_req), .d_adr(d_adr), .d_memwrite(d_memwrite), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall), .err(err),
    .m_instrreq(m_instrreq), .m_instradr(m_instradr), .m_instr(m_instr), .m_val(m_val),
    .m_datareq(m_datareq), .m_dataadr(m_dataadr), .m_memwrite(m_memwrite),
    .m_writedata(m_writedata), .m_readdata(m_readdata), .m_dack(m_dack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iadr, input logic dreq,
                               input logic [N-1:0] dadr, input logic [1:0] dmw,
                               input logic [N-1:0] dwd);
    i_req      = ireq;
    i_adr      = iadr;
    d_req      = dreq;
    d_adr      = dadr;
    d_memwrite = dmw;
    d_wdata    = dwd;
  endtask

  // Called in the first cycle of an I grant; ends in the i_done cycle with i_req dropped.
  task automatic serveIBurst(input logic [31:0] adr, input int maxgap, input bit fixed);
    logic [31:0] w;
    checkOutput("grant_instrreq", m_instrreq, 1'b1);
    checkOutput("grant_instradr", m_instradr, adr);
    checkOutput("grant_no_datareq", m_datareq, 1'b0);
    checkOutput("grant_no_memwrite", m_memwrite, 2'd0);
    for (int b = 0; b < BEATS; b++) begin
      int gap;
      gap = $urandom_range(0, maxgap);
      for (int g = 0; g < gap; g++) begin
        m_val = 1'b0;
        tick();
        checkOutput("ivalid_gap", i_valid, 1'b0);
        checkOutput("dstall_during_i", d_stall, d_req);
      end
      w       = fixed ? 32'hA0 + 32'(b) : $urandom;
      m_instr = w;
      m_val   = 1'b1;
      tick();
      m_val   = 1'b0;
      m_instr = $urandom;
      checkOutput("ivalid_beat", i_valid, 1'b1);
      checkOutput("idata_beat", i_data, w);
      checkOutput("idone_beat", i_done, (b == BEATS - 1));
      checkOutput("err_beat", err, 1'b0);
    end
    checkOutput("instrreq_drop", m_instrreq, 1'b0);
    i_req        = 1'b0;
    model_last_i = 1'b1;
  endtask

  task automatic serveDRead(input logic [N-1:0] adr, input int delay, input logic [N-1:0] data);
    checkOutput("grant_datareq", m_datareq, 1'b1);
    checkOutput("grant_dataadr", m_dataadr, adr);
    checkOutput("grant_no_instrreq", m_instrreq, 1'b0);
    checkOutput("grant_rd_memwrite", m_memwrite, 2'd0);
    checkOutput("dstall_rd", d_stall, 1'b1);
    for (int k = 0; k < delay; k++) begin
      m_dack     = 1'b0;
      m_readdata = {$urandom, $urandom};
      m_val      = 1'($urandom_range(0, 1));
      m_instr    = $urandom;
      tick();
      checkOutput("ddone_wait", d_done, 1'b0);
      checkOutput("dstall_wait", d_stall, 1'b1);
      checkOutput("ivalid_stray", i_valid, 1'b0);
    end
    m_val      = 1'b0;
    m_dack     = 1'b1;
    m_readdata = data;
    tick();
    m_dack     = 1'b0;
    m_readdata = ~data;
    checkOutput("ddone_rd", d_done, 1'b1);
    checkOutput("drdata_rd", d_rdata, data);
    checkOutput("dstall_release", d_stall, 1'b0);
    checkOutput("datareq_drop", m_datareq, 1'b0);
    checkOutput("err_rd", err, 1'b0);
    d_req        = 1'b0;
    model_last_i = 1'b0;
    model_rdata  = data;
  endtask

  task automatic serveDWrite(input logic [N-1:0] adr, input logic [1:0] code,
                             input logic [N-1:0] data);
    checkOutput("grant_memwrite", m_memwrite, code);
    checkOutput("grant_wr_adr", m_dataadr, adr);
    checkOutput("grant_wr_data", m_writedata, data);
    checkOutput("grant_wr_no_datareq", m_datareq, 1'b0);
    checkOutput("dstall_wr", d_stall, 1'b1);
    d_adr      = {$urandom, $urandom};
    d_wdata    = {$urandom, $urandom};
    d_memwrite = 2'd3;
    tick();
    checkOutput("memwrite_one_cycle", m_memwrite, 2'd0);
    checkOutput("ddone_wr", d_done, 1'b1);
    checkOutput("wr_adr_held", m_dataadr, adr);
    checkOutput("wr_data_held", m_writedata, data);
    checkOutput("drdata_kept", d_rdata, model_rdata);
    d_req        = 1'b0;
    model_last_i = 1'b0;
  endtask

  task automatic serveD(input logic [N-1:0] adr, input logic [1:0] code, input logic [N-1:0] data);
    if (code == 2'd0) serveDRead(adr, $urandom_range(0, 5), {$urandom, $urandom});
    else              serveDWrite(adr, code, data);
  endtask

  initial begin
    logic [N-1:0] rd;
    $display("[TB] mem_port_arbiter bench start");
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, '0, 2'd0, '0);
    m_instr = '0; m_val = 1'b0; m_readdata = '0; m_dack = 1'b0;
    model_last_i = 1'b0;
    model_rdata  = '0;
    repeat (3) tick();
    checkOutput("rst_ivalid", i_valid, 1'b0);
    checkOutput("rst_idone", i_done, 1'b0);
    checkOutput("rst_ddone", d_done, 1'b0);
    checkOutput("rst_dstall", d_stall, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_instrreq", m_instrreq, 1'b0);
    checkOutput("rst_datareq", m_datareq, 1'b0);
    checkOutput("rst_memwrite", m_memwrite, 2'd0);
    checkOutput("rst_drdata", d_rdata, '0);
    reset = 1'b1;
    tick();

    // Simultaneous requests after reset: I wins, then D; I re-requests at once and D goes first.
    applyStimulus(1'b1, 32'h100, 1'b1, 64'h20, 2'd0, '0);
    tick();
    serveIBurst(32'h100, 2, 1'b0);
    i_req = 1'b1;
    i_adr = 32'h200;
    tick();
    serveDRead(64'h20, 1, 64'hCAFE_0001);
    d_req = 1'b1;
    tick();
    checkOutput("rr_i_after_d", m_instrreq, 1'b1);
    serveIBurst(32'h200, 1, 1'b0);
    tick();
    checkOutput("rr_d_after_i", m_datareq, 1'b1);
    serveDRead(64'h20, 0, 64'hCAFE_0002);
    tick();

    applyStimulus(1'b1, 32'h40, 1'b0, '0, 2'd0, '0);
    tick();
    serveIBurst(32'h40, 0, 1'b1);
    tick();
    checkOutput("instrreq_after_burst", m_instrreq, 1'b0);

    applyStimulus(1'b0, 32'h0, 1'b1, 64'h18, 2'd0, '0);
    tick();
    serveDRead(64'h18, 3, 64'h1234);
    tick();
    checkOutput("drdata_persist", d_rdata, 64'h1234);

    applyStimulus(1'b0, 32'h0, 1'b1, 64'h7, 2'd2, 64'h0123_4567_89AB_CDEF);
    tick();
    serveDWrite(64'h7, 2'd2, 64'h0123_4567_89AB_CDEF);
    tick();

    // D read whose ack never comes.
    applyStimulus(1'b0, 32'h0, 1'b1, 64'h50, 2'd0, '0);
    tick();
    checkOutput("to_grant", m_datareq, 1'b1);
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      checkOutput("to_d_wait", d_done | err, 1'b0);
    end
    tick();
    checkOutput("to_d_done", d_done, 1'b1);
    checkOutput("to_d_err", err, 1'b1);
    checkOutput("to_d_datareq", m_datareq, 1'b0);
    checkOutput("to_d_rdata", d_rdata, model_rdata);
    d_req = 1'b0;
    model_last_i = 1'b0;
    tick();
    checkOutput("to_err_pulse", err, 1'b0);

    // I burst that stalls after two beats.
    applyStimulus(1'b1, 32'h80, 1'b0, '0, 2'd0, '0);
    tick();
    checkOutput("to_i_grant", m_instrreq, 1'b1);
    for (int b = 0; b < 2; b++) begin
      m_instr = 32'h5A00 + 32'(b);
      m_val   = 1'b1;
      tick();
      checkOutput("to_i_beat", i_data, 32'h5A00 + 32'(b));
    end
    m_val = 1'b0;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      checkOutput("to_i_wait", i_done, 1'b0);
    end
    tick();
    checkOutput("to_i_done", i_done, 1'b1);
    checkOutput("to_i_err", err, 1'b1);
    checkOutput("to_i_valid", i_valid, 1'b0);
    checkOutput("to_i_instrreq", m_instrreq, 1'b0);
    i_req = 1'b0;
    model_last_i = 1'b1;
    tick();

    // Reset arriving with beat 4 of a burst.
    applyStimulus(1'b1, 32'h300, 1'b0, '0, 2'd0, '0);
    tick();
    for (int b = 0; b < 4; b++) begin
      m_instr = $urandom;
      m_val   = 1'b1;
      tick();
    end
    reset   = 1'b0;
    m_instr = 32'hDEAD_BEEF;
    tick();
    reset = 1'b1;
    m_val = 1'b0;
    model_last_i = 1'b0;
    checkOutput("mid_rst_ivalid", i_valid, 1'b0);
    checkOutput("mid_rst_idone", i_done, 1'b0);
    checkOutput("mid_rst_instrreq", m_instrreq, 1'b0);
    checkOutput("mid_rst_instradr", m_instradr, 32'h0);
    checkOutput("mid_rst_idata", i_data, 32'h0);
    checkOutput("mid_rst_err", err, 1'b0);
    tick();
    serveIBurst(32'h300, 1, 1'b0);
    tick();

    // Random transactions, ordered by the round-robin ownership model.
    for (int it = 0; it < 16; it++) begin
      int kind;
      logic [31:0]  ia;
      logic [N-1:0] da, dd;
      logic [1:0]   dmw;
      logic         ireq, dreq, first_i;
      kind = $urandom_range(0, 3);
      ia   = $urandom & 32'hFFFF_FFFC;
      da   = {$urandom, $urandom};
      dd   = {$urandom, $urandom};
      dmw  = (kind == 1) ? 2'd0 : (kind == 2) ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
      ireq = (kind == 0) || (kind == 3);
      dreq = (kind != 0);
      applyStimulus(ireq, ia, dreq, da, dmw, dd);
      tick();
      first_i = ireq && (!dreq || !model_last_i);
      if (first_i) begin
        serveIBurst(ia, 3, 1'b0);
        if (dreq) begin
          tick();
          serveD(da, dmw, dd);
        end
      end else begin
        serveD(da, dmw, dd);
        if (ireq) begin
          tick();
          serveIBurst(ia, 3, 1'b0);
        end
      end
      tick();
    end

    rd = model_rdata;
    checkOutput("final_drdata", d_rdata, rd);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
